// File: rtl/dm_responder_if.sv
// Request/response bus between a CPU-side master and the data-memory responder.
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder with fixed wait states and
// byte-enabled word storage. One request in flight; response held until taken.
module dm_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  dm_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] waitCnt;

  logic        latWrite;
  logic [31:0] latAddr;
  logic [31:0] latWdata;
  logic [3:0]  latBe;

  logic        reqReady;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respErr;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept_c;
  logic          enterResp_c;
  logic          curWrite_c;
  logic [31:0]   curAddr_c;
  logic [31:0]   curWdata_c;
  logic [3:0]    curBe_c;
  logic          err_c;
  logic [AW-1:0] wordIdx_c;

  // Select the live request in IDLE (zero-wait path) or the latched one otherwise; decode fault and index
  always_comb begin
    accept_c    = bus.req_valid && reqReady;
    curWrite_c  = latWrite;
    curAddr_c   = latAddr;
    curWdata_c  = latWdata;
    curBe_c     = latBe;
    if (state == IDLE) begin
      curWrite_c = bus.req_write;
      curAddr_c  = bus.req_addr;
      curWdata_c = bus.req_wdata;
      curBe_c    = bus.req_be;
    end
    err_c       = (curAddr_c[1:0] != 2'b00) || (curAddr_c[31:2] >= 30'(DEPTH_WORDS));
    wordIdx_c   = curAddr_c[AW+1:2];
    enterResp_c = ((state == IDLE) && accept_c && NO_WAIT) ||
                  ((state == WAIT) && (waitCnt == '0));
  end

  // Byte-lane store committed on the edge that enters RESP; storage survives reset
  always_ff @(posedge clk) begin
    if (!rst && enterResp_c && curWrite_c && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (curBe_c[b]) begin
          mem[wordIdx_c][8*b +: 8] <= curWdata_c[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      reqReady  <= 1'b1;
      respValid <= 1'b0;
      respRdata <= '0;
      respErr   <= 1'b0;
      latWrite  <= 1'b0;
      latAddr   <= '0;
      latWdata  <= '0;
      latBe     <= '0;
    end else begin
      if (enterResp_c) begin
        state     <= RESP;
        reqReady  <= 1'b0;
        respValid <= 1'b1;
        respErr   <= err_c;
        respRdata <= (!err_c && !curWrite_c) ? mem[wordIdx_c] : '0;
      end
      case (state)
        IDLE: begin
          if (accept_c) begin
            latWrite <= bus.req_write;
            latAddr  <= bus.req_addr;
            latWdata <= bus.req_wdata;
            latBe    <= bus.req_be;
            reqReady <= 1'b0;
            if (!NO_WAIT) begin
              state   <= WAIT;
              waitCnt <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (waitCnt != '0) begin
            waitCnt <= waitCnt - CW'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state     <= IDLE;
            reqReady  <= 1'b1;
            respValid <= 1'b0;
            respRdata <= '0;
            respErr   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          reqReady  <= 1'b1;
          respValid <= 1'b0;
          respRdata <= '0;
          respErr   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = reqReady;
  assign bus.resp_valid = respValid;
  assign bus.resp_rdata = respRdata;
  assign bus.resp_err   = respErr;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench: directed vector table, randomized traffic against a
// word-array memory model, reset corner cases, and a zero-wait instance.
module tb_dm_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned NVEC  = 16;

  logic clk;
  logic rst;

  dm_responder_if busA ();
  dm_responder_if busB ();

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dutA (.clk(clk), .rst(rst), .bus(busA));
  dm_responder #(.DEPTH_WORDS(16),    .WAIT_CYCLES(0)) dutB (.clk(clk), .rst(rst), .bus(busB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  logic [31:0] model [DEPTH];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expRd;
    logic        expErr;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance; hold = cycles resp_ready stays low in RESP
  task automatic doReq(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
    int guard;
    rd = '0; er = 1'b0; lat = 0;
    @(negedge clk);
    busA.req_valid  = 1'b1;
    busA.req_write  = wr;
    busA.req_addr   = a;
    busA.req_wdata  = wd;
    busA.req_be     = be;
    busA.resp_ready = 1'b0;
    guard = 0;
    while (!busA.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!busA.req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready stayed %b, expected 1", busA.req_ready);
      busA.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    busA.req_valid = 1'b0;
    busA.req_write = 1'($urandom);
    busA.req_addr  = $urandom;
    busA.req_wdata = $urandom;
    busA.req_be    = 4'($urandom);
    do begin
      @(negedge clk);
      lat++;
    end while (!busA.resp_valid && lat < 40);
    if (!busA.resp_valid) begin
      tests++; fails++;
      $display("FAIL resp_timeout: resp_valid %b after %0d cycles, expected 1", busA.resp_valid, lat);
      return;
    end
    rd = busA.resp_rdata;
    er = busA.resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      tests++;
      if (busA.resp_valid !== 1'b1 || busA.resp_rdata !== rd ||
          busA.resp_err !== er || busA.req_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable: valid %b rdata %h err %b ready %b, expected 1 %h %b 0",
                 busA.resp_valid, busA.resp_rdata, busA.resp_err, busA.req_ready, rd, er);
      end
    end
    busA.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    busA.resp_ready = 1'b0;
    @(negedge clk);
    check32("ready_after_handshake", 32'(busA.req_ready), 32'd1);
    check32("valid_after_handshake", 32'(busA.resp_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          accB;
    int          rvB;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] expRd;
    logic        expErr;
    int          sel;
    int unsigned idx;

    tests = 0;
    fails = 0;

    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,       32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b0, 32'h13,       32'h0,        4'h0, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 32'h0,        32'h01234567, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 32'h400,      32'hCAFEF00D, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h0,        32'h0,        4'h0, 32'h01234567, 1'b0};
    vecs[8]  = '{1'b1, 32'h10,       32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[10] = '{1'b1, 32'h3FC,      32'hAABBCCDD, 4'hF, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h3FC,      32'h0,        4'h0, 32'hAABBCCDD, 1'b0};
    vecs[12] = '{1'b0, 32'h3FE,      32'h0,        4'h0, 32'h0,        1'b1};
    vecs[13] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[14] = '{1'b1, 32'h12,       32'h0,        4'hF, 32'h0,        1'b1};
    vecs[15] = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDE22BE44, 1'b0};

    busA.req_valid = 1'b0; busA.req_write = 1'b0; busA.req_addr = '0;
    busA.req_wdata = '0;   busA.req_be = '0;      busA.resp_ready = 1'b0;
    busB.req_valid = 1'b0; busB.req_write = 1'b0; busB.req_addr = '0;
    busB.req_wdata = '0;   busB.req_be = '0;      busB.resp_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check32("reset_resp_valid", 32'(busA.resp_valid), 32'd0);
    check32("reset_resp_rdata", busA.resp_rdata, 32'd0);
    check32("reset_resp_err",   32'(busA.resp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check32("reset_req_ready",  32'(busA.req_ready), 32'd1);
    check32("reset_req_ready_b", 32'(busB.req_ready), 32'd1);

    // Zero-wait instance: back-to-back stores complete one per two cycles
    busB.req_valid = 1'b1; busB.req_write = 1'b1; busB.req_addr = 32'h8;
    busB.req_wdata = 32'h0BADF00D; busB.req_be = 4'hF; busB.resp_ready = 1'b1;
    accB = 0; rvB = 0;
    for (int i = 0; i < 10; i++) begin
      if (busB.req_ready) accB++;
      if (busB.resp_valid) rvB++;
      @(negedge clk);
    end
    busB.req_valid = 1'b0;
    check32("b2b_accepts", 32'(accB), 32'd5);
    check32("b2b_resps",   32'(rvB),  32'd5);
    busB.req_valid = 1'b1; busB.req_write = 1'b0; busB.req_addr = 32'h8;
    @(posedge clk); #1;
    busB.req_valid = 1'b0; busB.req_addr = 32'hFFFFFFFF;
    @(negedge clk);
    check32("b_lat1_valid", 32'(busB.resp_valid), 32'd1);
    check32("b_load_rdata", busB.resp_rdata, 32'h0BADF00D);
    @(posedge clk); #1;
    @(negedge clk);
    busB.req_valid = 1'b1; busB.req_write = 1'b0; busB.req_addr = 32'h40;
    @(posedge clk); #1;
    busB.req_valid = 1'b0;
    @(negedge clk);
    check32("b_oor_valid", 32'(busB.resp_valid), 32'd1);
    check32("b_oor_err",   32'(busB.resp_err), 32'd1);
    check32("b_oor_rdata", busB.resp_rdata, 32'd0);
    @(posedge clk); #1;
    busB.resp_ready = 1'b0;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      doReq(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, (i == 3) ? 5 : (i % 2), rd, er, lat);
      check32($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
      check32($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].expErr));
      check32($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // Fill every word so the model is fully known
    for (int w = 0; w < DEPTH; w++) begin
      wd = $urandom;
      doReq(1'b1, 32'(w) * 32'd4, wd, 4'hF, 0, rd, er, lat);
      model[w] = wd;
      check32("fill_err", 32'(er), 32'd0);
    end

    // Randomized traffic against the memory model
    for (int n = 0; n < 300; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'($urandom_range(DEPTH, 5000)) * 32'd4;
      else               a = $urandom;
      wd = $urandom;
      be = 4'($urandom);
      expErr = ((a % 32'd4) != 0) || ((a / 32'd4) >= 32'(DEPTH));
      expRd  = '0;
      if (!expErr) begin
        idx = a / 32'd4;
        if (wr) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
          end
        end else begin
          expRd = model[idx];
        end
      end
      doReq(wr, a, wd, be, $urandom_range(0, 3), rd, er, lat);
      check32($sformatf("rand%0d_rdata", n), rd, expRd);
      check32($sformatf("rand%0d_err", n), 32'(er), 32'(expErr));
      check32($sformatf("rand%0d_latency", n), 32'(lat), 32'd3);
    end

    // Reset during WAIT of a store to 0x20 abandons it
    @(negedge clk);
    busA.req_valid = 1'b1; busA.req_write = 1'b1; busA.req_addr = 32'h20;
    busA.req_wdata = ~model[8]; busA.req_be = 4'hF;
    @(posedge clk); #1;
    busA.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check32("rst_wait_valid", 32'(busA.resp_valid), 32'd0);
    check32("rst_wait_rdata", busA.resp_rdata, 32'd0);
    check32("rst_wait_err",   32'(busA.resp_err), 32'd0);
    check32("rst_wait_ready", 32'(busA.req_ready), 32'd1);
    doReq(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    check32("rst_wait_word_unchanged", rd, model[8]);

    // Reset while holding a load response in RESP
    @(negedge clk);
    busA.req_valid = 1'b1; busA.req_write = 1'b0; busA.req_addr = 32'h24;
    @(posedge clk); #1;
    busA.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check32("rst_resp_pre_valid", 32'(busA.resp_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check32("rst_resp_valid", 32'(busA.resp_valid), 32'd0);
    check32("rst_resp_rdata", busA.resp_rdata, 32'd0);
    check32("rst_resp_ready", 32'(busA.req_ready), 32'd1);
    doReq(1'b0, 32'h24, 32'h0, 4'h0, 0, rd, er, lat);
    check32("mem_survives_reset", rd, model[9]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words of backing storage; power of two, 4..4096.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states between request accept and response, 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i gates byte lane [8i+7:8i].
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  CPU accepts response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request faulted (misaligned or out of range).

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; req_ready SHALL NOT depend combinationally on req_valid.
REQ-017 Accept = req_valid && req_ready; on accept, req_write, req_addr, req_wdata, req_be SHALL be latched; later input changes have no effect.
REQ-018 Accept with WAIT_CYCLES > 0: IDLE -> WAIT; wait counter loaded with WAIT_CYCLES-1.
REQ-019 In WAIT: counter decrements each cycle; at 0 the next state is RESP.
REQ-020 Accept with WAIT_CYCLES = 0: IDLE -> RESP directly.
REQ-021 Latency: resp_valid SHALL first assert exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-022 In RESP: resp_valid=1; resp_rdata, resp_err stable until resp_valid && resp_ready, then -> IDLE.
REQ-023 Back-to-back: a new request SHALL be accepted no earlier than the cycle after the response handshake (one request in flight, max).
REQ-024 Error: latched addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS -> resp_err=1, resp_rdata=0, no memory write.
REQ-025 Store, no error: on entry to RESP, byte lanes with be=1 written to word addr[31:2]; lanes with be=0 unchanged; resp_rdata=0.
REQ-026 Store with be=4'b0000: no change, resp_err=0.
REQ-027 Load, no error: resp_rdata = word at addr[31:2], sampled on entry to RESP (reflects all prior completed stores).
REQ-028 Address arithmetic: word index = addr[log2(DEPTH_WORDS)+1:2] after range check; no wrap-around aliasing.

Reset
REQ-029 rst=1 at a clock edge: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready=1 the cycle after rst deasserts.
REQ-030 rst mid-operation (WAIT or RESP) SHALL abandon the request; a store not yet in RESP SHALL NOT be written.
REQ-031 Memory contents SHALL NOT be cleared by rst.

Verification
REQ-032 Store addr 0x10, wdata 0xDEADBEEF, be 1111; load 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0, resp_valid 3 cycles after each accept (WAIT_CYCLES=2).
REQ-033 Word 0x10 = 0xDEADBEEF; store be 0101, wdata 0x11223344; load -> 0xDE22BE44.
REQ-034 Load addr 0x13 -> resp_err 1, rdata 0; store addr 0x400 (DEPTH 256) -> resp_err 1, memory unchanged.
REQ-035 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata stable, req_ready 0; raise -> IDLE next cycle.
REQ-036 WAIT_CYCLES=0: load accepted at edge n -> resp_valid at n+1; back-to-back requests with resp_ready=1 complete one per 2 cycles.
REQ-037 Assert rst during WAIT of a store to 0x20 -> outputs 0, word 0x20 unchanged on subsequent load.
